spi_flash_bridge: RTL and testbench

- Registered SPI pass-through between the external SPI master header (EXT_*) and NUM_FLASH on-board SPI flash devices.
- External CS_n, CLK and DI are synchronised into the 48 MHz CLK domain and re-driven to the flash selected at transaction start.
- The block sniffs each transaction's opcode and bit count for status.
- Optionally it guards against write-enable commands (WREN, 0x06) while write-protect is asserted.

---
 rtl/spi_flash_bridge.sv | 179 +++++++++++++++++
 tb/tb_spi_flash_bridge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_bridge.sv
// rtl/spi_flash_bridge.sv - registered SPI pass-through from an external master to NUM_FLASH flash devices
// Optional write-enable guard while WP is high: define FLASH_WREN_GUARD_EN.
module spi_flash_bridge #(
  parameter int NUM_FLASH    = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int GUARD_CYCLES = 4,
  localparam int SEL_W = (NUM_FLASH > 1) ? $clog2(NUM_FLASH) : 1
) (
  input  logic                 CLK,
  input  logic                 RESET_n,
  input  logic                 EXT_CS_n,
  input  logic                 EXT_CLK,
  input  logic                 EXT_DI,
  output logic                 EXT_DO,
  input  logic [SEL_W-1:0]     SEL,
  input  logic                 WP,
  output logic [NUM_FLASH-1:0] FLASH_CS_n,
  output logic                 FLASH_CLK,
  output logic                 FLASH_DI,
  input  logic [NUM_FLASH-1:0] FLASH_DO,
  output logic                 BUSY,
  output logic [7:0]           LAST_OPCODE,
  output logic [7:0]           LAST_BITS,
  output logic                 BLOCKED
);

  localparam int GC_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, ACTIVE, GUARD_HI, GUARD_LO, RELEASE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, clk_sync, di_sync;
  logic                   cs_s, clk_s, di_s, cs_d, clk_d;
  logic                   cs_fall, cs_rise, clk_rise;

  state_t                 state;
  logic [SEL_W-1:0]       sel_q, sel_start;
  logic [NUM_FLASH-1:0]   cs_start;
  logic [7:0]             bit_cnt, cnt_nxt;
  logic [7:0]             op_sr, sr_nxt, op_pad;
  logic [GC_W-1:0]        gcnt;
  logic                   pending;
  logic                   guard;

  // Identical stage counts on all three inputs keep CLK/DI/CS relative timing intact.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cs_sync  <= '1;
      clk_sync <= '0;
      di_sync  <= '0;
      cs_d     <= 1'b1;
      clk_d    <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], EXT_CS_n};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], EXT_CLK};
      di_sync  <= {di_sync[SYNC_STAGES-2:0], EXT_DI};
      cs_d     <= cs_s;
      clk_d    <= clk_s;
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign di_s     = di_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign clk_rise = ~clk_d & clk_s;

  always_comb begin
    sel_start = SEL;
    if (32'(SEL) >= NUM_FLASH) sel_start = '0;
    for (int i = 0; i < NUM_FLASH; i++) cs_start[i] = (sel_start != SEL_W'(i));

    cnt_nxt = bit_cnt;
    sr_nxt  = op_sr;
    if (clk_rise) begin
      if (bit_cnt != 8'hFF) cnt_nxt = bit_cnt + 8'd1;
      if (bit_cnt < 8'd8)   sr_nxt  = {op_sr[6:0], di_s};
    end
    // Short commands are left-justified so the opcode reads as the first bits sent.
    op_pad = (cnt_nxt < 8'd8) ? (sr_nxt << (4'd8 - cnt_nxt[3:0])) : sr_nxt;

`ifdef FLASH_WREN_GUARD_EN
    guard = WP && (op_pad == 8'h06) && (cnt_nxt == 8'd8);
`else
    guard = WP & 1'b0;
`endif
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state       <= IDLE;
      sel_q       <= '0;
      bit_cnt     <= '0;
      op_sr       <= '0;
      gcnt        <= '0;
      pending     <= 1'b0;
      FLASH_CS_n  <= '1;
      FLASH_CLK   <= 1'b0;
      FLASH_DI    <= 1'b0;
      EXT_DO      <= 1'b0;
      BUSY        <= 1'b0;
      LAST_OPCODE <= '0;
      LAST_BITS   <= '0;
      BLOCKED     <= 1'b0;
    end else begin
      EXT_DO <= 1'b0;
      case (state)
        IDLE: begin
          FLASH_CLK <= clk_s;
          FLASH_DI  <= di_s;
          pending   <= 1'b0;
          // A start seen during guard/release is honoured only if CS is still low.
          if (cs_fall || (pending && !cs_s)) begin
            sel_q      <= sel_start;
            bit_cnt    <= '0;
            op_sr      <= '0;
            FLASH_CS_n <= cs_start;
            BUSY       <= 1'b1;
            state      <= ACTIVE;
          end
        end
        ACTIVE: begin
          FLASH_CLK <= clk_s;
          FLASH_DI  <= di_s;
          EXT_DO    <= FLASH_DO[sel_q];
          bit_cnt   <= cnt_nxt;
          op_sr     <= sr_nxt;
          if (cs_rise) begin
            LAST_OPCODE <= op_pad;
            LAST_BITS   <= cnt_nxt;
            if (guard) begin
              FLASH_CLK <= 1'b1;
              FLASH_DI  <= 1'b0;
              gcnt      <= '0;
              state     <= GUARD_HI;
            end else begin
              FLASH_CS_n <= '1;
              BUSY       <= 1'b0;
              state      <= RELEASE;
            end
          end
        end
        GUARD_HI: begin
          if (cs_fall) pending <= 1'b1;
          if (gcnt == GC_W'(GUARD_CYCLES - 1)) begin
            gcnt      <= '0;
            FLASH_CLK <= 1'b0;
            state     <= GUARD_LO;
          end else begin
            gcnt <= gcnt + GC_W'(1);
          end
        end
        GUARD_LO: begin
          if (cs_fall) pending <= 1'b1;
          // The extra clock makes the flash see a 9-bit command and drop it.
          if (gcnt == GC_W'(GUARD_CYCLES - 1)) begin
            gcnt       <= '0;
            BLOCKED    <= 1'b1;
            FLASH_CS_n <= '1;
            FLASH_CLK  <= clk_s;
            FLASH_DI   <= di_s;
            BUSY       <= 1'b0;
            state      <= RELEASE;
          end else begin
            gcnt <= gcnt + GC_W'(1);
          end
        end
        RELEASE: begin
          FLASH_CLK <= clk_s;
          FLASH_DI  <= di_s;
          if (cs_fall) pending <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_bridge.sv
// tb/tb_spi_flash_bridge.sv - self-checking bench for spi_flash_bridge with behavioural flash models
`timescale 1ns/1ps
module tb_spi_flash_bridge;

  localparam real T_CLK_HALF = 10.417;
  localparam int  T_HALF     = 125;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       ext_cs_n = 1'b1, ext_clk = 1'b0, ext_di = 1'b0, wp = 1'b0;
  logic       sel = 1'b0;
  logic [1:0] sel3 = 2'd3;
  logic       ext_do, fclk, fdi, busy, blocked;
  logic [1:0] fcs, fdo;
  logic [7:0] last_op, last_bits;
  logic       ext_do3, fclk3, fdi3, busy3, blocked3;
  logic [2:0] fcs3;
  logic [2:0] fdo3 = 3'b000;
  logic [7:0] last_op3, last_bits3;

  int n_cmp = 0, n_fail = 0;

  always #(T_CLK_HALF) clk = ~clk;

  spi_flash_bridge u_dut (
    .CLK(clk), .RESET_n(rst_n), .EXT_CS_n(ext_cs_n), .EXT_CLK(ext_clk), .EXT_DI(ext_di),
    .EXT_DO(ext_do), .SEL(sel), .WP(wp), .FLASH_CS_n(fcs), .FLASH_CLK(fclk), .FLASH_DI(fdi),
    .FLASH_DO(fdo), .BUSY(busy), .LAST_OPCODE(last_op), .LAST_BITS(last_bits), .BLOCKED(blocked)
  );

  spi_flash_bridge #(.NUM_FLASH(3)) u_dut3 (
    .CLK(clk), .RESET_n(rst_n), .EXT_CS_n(ext_cs_n), .EXT_CLK(ext_clk), .EXT_DI(ext_di),
    .EXT_DO(ext_do3), .SEL(sel3), .WP(wp), .FLASH_CS_n(fcs3), .FLASH_CLK(fclk3), .FLASH_DI(fdi3),
    .FLASH_DO(fdo3), .BUSY(busy3), .LAST_OPCODE(last_op3), .LAST_BITS(last_bits3), .BLOCKED(blocked3)
  );

  // Flash model: counts clocks, captures the opcode, answers 0x9F with its ID, latches WREN on 8 bits.
  for (genvar g = 0; g < 2; g++) begin : g_flash
    localparam logic [23:0] ID = (g == 1) ? 24'hEF4018 : 24'hC22017;
    int          edges = 0, last_edges = 0, sel_cnt = 0, wren_cnt = 0;
    logic [7:0]  op = '0;
    logic [23:0] id_sr = '0;
    logic        do_bit = 1'b0, cs_prev = 1'b1, clk_prev = 1'b0;
    assign fdo[g] = do_bit;
    always @(fcs[g] or fclk) begin
      if (cs_prev && !fcs[g]) begin
        edges = 0; op = '0; id_sr = ID; sel_cnt++;
      end else if (!cs_prev && fcs[g]) begin
        last_edges = edges;
        if (edges == 8 && op == 8'h06) wren_cnt++;
        do_bit = 1'b0;
      end
      if (!fcs[g] && !clk_prev && fclk) begin
        if (edges < 8) op = {op[6:0], fdi};
        edges++;
      end
      if (!fcs[g] && clk_prev && !fclk && edges >= 8 && op == 8'h9F) begin
        do_bit = id_sr[23];
        id_sr  = {id_sr[22:0], 1'b0};
      end
      cs_prev  = fcs[g];
      clk_prev = fclk;
    end
  end

  function automatic int dev_sel_cnt(input logic d);
    return d ? g_flash[1].sel_cnt : g_flash[0].sel_cnt;
  endfunction
  function automatic int dev_last_edges(input logic d);
    return d ? g_flash[1].last_edges : g_flash[0].last_edges;
  endfunction
  function automatic logic [23:0] dev_id(input logic d);
    return d ? 24'hEF4018 : 24'hC22017;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    ext_di = b;
    #(T_HALF);
    r = ext_do;
    ext_clk = 1'b1;
    #(T_HALF);
    ext_clk = 1'b0;
  endtask

  task automatic spi_xfer(input int n, input logic [31:0] tx, output logic [31:0] rx,
                          output logic [1:0] cs_mid, output logic [2:0] cs3_mid, output logic busy_mid);
    logic r;
    rx = '0;
    @(negedge clk);
    ext_cs_n = 1'b0;
    ext_di   = tx[31];
    #(T_HALF);
    cs_mid = fcs; cs3_mid = fcs3; busy_mid = busy;
    for (int i = 0; i < n; i++) begin
      spi_bit((i < 32) ? tx[31-i] : 1'b0, r);
      rx = {rx[30:0], r};
    end
    #(T_HALF);
    ext_cs_n = 1'b1;
    ext_di   = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        s;
    int          n;
    logic [31:0] tx;
    logic [7:0]  op;
    logic [7:0]  bits;
    logic [31:0] rx;
    logic [1:0]  cs;
  } vec_t;
  vec_t vecs[7];

  initial begin
    logic [31:0] rx, tx, exp_rx;
    logic [1:0]  cs_mid;
    logic [2:0]  cs3_mid;
    logic        busy_mid, r, s, b;
    logic [7:0]  exp_op;
    int          n, c0, c1, w0;

    vecs[0] = '{1'b1, 32, 32'h9F000000, 8'h9F, 8'd32, 32'h00EF4018, 2'b01};
    vecs[1] = '{1'b0, 32, 32'h9F000000, 8'h9F, 8'd32, 32'h00C22017, 2'b10};
    vecs[2] = '{1'b0,  3, 32'hA0000000, 8'hA0, 8'd3,  32'h0,        2'b10};
    vecs[3] = '{1'b1,  0, 32'h00000000, 8'h00, 8'd0,  32'h0,        2'b01};
    vecs[4] = '{1'b0,  8, 32'h03000000, 8'h03, 8'd8,  32'h0,        2'b10};
    vecs[5] = '{1'b1, 13, 32'hFFF80000, 8'hFF, 8'd13, 32'h0,        2'b01};
    vecs[6] = '{1'b0,  7, 32'hFE000000, 8'hFE, 8'd7,  32'h0,        2'b10};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n", fcs, 2'b11);
    check("rst_flash_clk", fclk, 0);
    check("rst_flash_di", fdi, 0);
    check("rst_ext_do", ext_do, 0);
    check("rst_busy", busy, 0);
    check("rst_last_op", last_op, 0);
    check("rst_last_bits", last_bits, 0);
    check("rst_blocked", blocked, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    for (int v = 0; v < 7; v++) begin
      sel = vecs[v].s;
      spi_xfer(vecs[v].n, vecs[v].tx, rx, cs_mid, cs3_mid, busy_mid);
      check($sformatf("vec%0d_op", v), last_op, vecs[v].op);
      check($sformatf("vec%0d_bits", v), last_bits, vecs[v].bits);
      check($sformatf("vec%0d_rx", v), rx, vecs[v].rx);
      check($sformatf("vec%0d_cs", v), cs_mid, vecs[v].cs);
      check($sformatf("vec%0d_busy_mid", v), busy_mid, 1);
      check($sformatf("vec%0d_busy_end", v), busy, 0);
      check($sformatf("vec%0d_cs_end", v), fcs, 2'b11);
      check($sformatf("vec%0d_oor_cs", v), cs3_mid, 3'b110);
      check($sformatf("vec%0d_oor_op", v), last_op3, vecs[v].op);
    end

    // SEL change mid-transaction must not move the chip select.
    sel = 1'b0;
    c0 = dev_sel_cnt(1'b0); c1 = dev_sel_cnt(1'b1);
    @(negedge clk);
    ext_cs_n = 1'b0;
    #(T_HALF);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, r);
    sel = 1'b1;
    for (int i = 0; i < 5; i++) spi_bit(1'b0, r);
    check("selchg_cs_mid", fcs, 2'b10);
    #(T_HALF);
    ext_cs_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("selchg_dev1_sel", dev_sel_cnt(1'b1) - c1, 0);
    check("selchg_dev0_sel", dev_sel_cnt(1'b0) - c0, 1);
    check("selchg_dev0_edges", dev_last_edges(1'b0), 8);
    check("selchg_op", last_op, 8'hE0);

    // WREN with WP high: guarded only when the feature is built in.
    sel = 1'b1; wp = 1'b1;
    w0 = g_flash[1].wren_cnt;
    spi_xfer(8, 32'h06000000, rx, cs_mid, cs3_mid, busy_mid);
`ifdef FLASH_WREN_GUARD_EN
    check("wren_wp_edges", dev_last_edges(1'b1), 9);
    check("wren_wp_wel", g_flash[1].wren_cnt - w0, 0);
    check("wren_wp_blocked", blocked, 1);
`else
    check("wren_wp_edges", dev_last_edges(1'b1), 8);
    check("wren_wp_wel", g_flash[1].wren_cnt - w0, 1);
    check("wren_wp_blocked", blocked, 0);
`endif
    check("wren_wp_op", last_op, 8'h06);
    check("wren_wp_bits", last_bits, 8);
    wp = 1'b0;
    w0 = g_flash[1].wren_cnt;
    spi_xfer(8, 32'h06000000, rx, cs_mid, cs3_mid, busy_mid);
    check("wren_nowp_edges", dev_last_edges(1'b1), 8);
    check("wren_nowp_wel", g_flash[1].wren_cnt - w0, 1);
`ifdef FLASH_WREN_GUARD_EN
    check("wren_nowp_blocked", blocked, 1);
`else
    check("wren_nowp_blocked", blocked, 0);
`endif

    // Bit counter saturation.
    sel = 1'b0;
    spi_xfer(300, 32'hA5000000, rx, cs_mid, cs3_mid, busy_mid);
    check("sat_bits", last_bits, 8'd255);
    check("sat_op", last_op, 8'hA5);
    check("sat_edges", dev_last_edges(1'b0), 300);

    // Randomised transactions against a first-principles model.
    for (int t = 0; t < 24; t++) begin
      s  = 1'($urandom_range(0, 1));
      n  = $urandom_range(0, 32);
      tx = $urandom();
      if ($urandom_range(0, 3) == 0) tx[31:24] = 8'h9F;
      exp_op = '0;
      for (int i = 0; i < n && i < 8; i++) exp_op[7-i] = tx[31-i];
      exp_rx = '0;
      for (int i = 0; i < n; i++) begin
        b = (tx[31:24] == 8'h9F && i >= 8) ? dev_id(s)[23-(i-8)] : 1'b0;
        exp_rx = {exp_rx[30:0], b};
      end
      c0 = dev_sel_cnt(1'b0); c1 = dev_sel_cnt(1'b1);
      sel = s;
      spi_xfer(n, tx, rx, cs_mid, cs3_mid, busy_mid);
      check($sformatf("rnd%0d_op", t), last_op, exp_op);
      check($sformatf("rnd%0d_bits", t), last_bits, n);
      check($sformatf("rnd%0d_rx", t), rx, exp_rx);
      check($sformatf("rnd%0d_cs", t), cs_mid, s ? 2'b01 : 2'b10);
      check($sformatf("rnd%0d_edges", t), dev_last_edges(s), n);
      check($sformatf("rnd%0d_sel0", t), dev_sel_cnt(1'b0) - c0, s ? 0 : 1);
      check($sformatf("rnd%0d_sel1", t), dev_sel_cnt(1'b1) - c1, s ? 1 : 0);
    end

    // Reset while ACTIVE.
    sel = 1'b1;
    @(negedge clk);
    ext_cs_n = 1'b0;
    #(T_HALF);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, r);
    check("rstmid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_cs_n", fcs, 2'b11);
    check("rstmid_flash_clk", fclk, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_last_bits", last_bits, 0);
    ext_cs_n = 1'b1;
    #(T_HALF);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rstmid_busy_after", busy, 0);
    spi_xfer(8, 32'h05000000, rx, cs_mid, cs3_mid, busy_mid);
    check("rstmid_next_cs", cs_mid, 2'b01);
    check("rstmid_next_op", last_op, 8'h05);
    check("rstmid_next_bits", last_bits, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
